// File: rtl/fe_transmit.sv
// UTMI front-end packet transmitter: buffers one packet, waits for a quiet bus,
// drives the PHY in normal opmode and streams PID, payload and optional CRC16.
module fe_transmit #(
   parameter int pBUF_ADDR_WIDTH  = 6,
   parameter int pTURNAROUND      = 4,
   parameter int pTXREADY_TIMEOUT = 1024
) (
   input  logic                       fe_clk,
   input  logic                       reset_i,
   input  logic                       I_buf_wr,
   input  logic [pBUF_ADDR_WIDTH-1:0] I_buf_addr,
   input  logic [7:0]                 I_buf_data,
   input  logic [pBUF_ADDR_WIDTH:0]   I_len,
   input  logic                       I_crc_enable,
   input  logic                       I_start,
   input  logic                       I_abort,
   input  logic                       fe_rxactive,
   input  logic                       fe_txready,
   output logic [7:0]                 O_fe_data,
   output logic                       O_fe_txvalid,
   output logic [1:0]                 O_opmode,
   output logic                       O_busy,
   output logic                       O_done,
   output logic                       O_error
);

   localparam int W    = pBUF_ADDR_WIDTH;
   localparam int TC_W = $clog2(pTURNAROUND + 1);
   localparam int TO_W = $clog2(pTXREADY_TIMEOUT + 1);
   localparam logic [W:0] MAX_LEN = {1'b1, {W{1'b0}}};

   typedef enum logic [2:0] {IDLE, WAIT_BUS, PRE, TX, POST} state_t;

   state_t           state_reg, state_next;
   logic [W:0]       len_reg, len_next;
   logic             crc_en_reg, crc_en_next;
   logic [W+1:0]     idx_reg, idx_next;
   logic             quiet_reg, quiet_next;
   logic [TC_W-1:0]  turn_reg, turn_next;
   logic [TO_W-1:0]  to_reg, to_next;
   logic [15:0]      crc_reg, crc_next;
   logic             txvalid_reg, txvalid_next;
   logic [1:0]       opmode_reg, opmode_next;
   logic             done_reg, done_next;
   logic             error_reg, error_next;

   logic [7:0]       buf_mem [2**W];
   logic [7:0]       rd_data_reg;
   logic [W-1:0]     rd_addr;
   logic [7:0]       tx_byte;
   logic [W+1:0]     len_ext, total_len;
   logic             consume, is_last, turn_done;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   // Registered-read buffer; rd_addr already points at the byte needed next cycle.
   always_ff @(posedge fe_clk) begin
      if (I_buf_wr)
         buf_mem[I_buf_addr] <= I_buf_data;
      rd_data_reg <= buf_mem[rd_addr];
   end

   assign len_ext   = {1'b0, len_reg};
   assign total_len = len_ext + (crc_en_reg ? (W+2)'(2) : (W+2)'(0));
   assign consume   = txvalid_reg & fe_txready;
   assign is_last   = (idx_reg == total_len - (W+2)'(1));
   assign turn_done = (turn_reg == TC_W'(pTURNAROUND - 1));

   // Past the payload the CRC register is complete; send its complement low byte first.
   always_comb begin
      if (idx_reg < len_ext)
         tx_byte = rd_data_reg;
      else if (idx_reg == len_ext)
         tx_byte = ~crc_reg[7:0];
      else
         tx_byte = ~crc_reg[15:8];
   end

   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state_reg   <= IDLE;
         len_reg     <= '0;
         crc_en_reg  <= 1'b0;
         idx_reg     <= '0;
         quiet_reg   <= 1'b0;
         turn_reg    <= '0;
         to_reg      <= '0;
         crc_reg     <= 16'hFFFF;
         txvalid_reg <= 1'b0;
         opmode_reg  <= 2'b01;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         len_reg     <= len_next;
         crc_en_reg  <= crc_en_next;
         idx_reg     <= idx_next;
         quiet_reg   <= quiet_next;
         turn_reg    <= turn_next;
         to_reg      <= to_next;
         crc_reg     <= crc_next;
         txvalid_reg <= txvalid_next;
         opmode_reg  <= opmode_next;
         done_reg    <= done_next;
         error_reg   <= error_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      crc_en_next  = crc_en_reg;
      idx_next     = idx_reg;
      quiet_next   = quiet_reg;
      turn_next    = turn_reg;
      to_next      = to_reg;
      crc_next     = crc_reg;
      txvalid_next = txvalid_reg;
      opmode_next  = opmode_reg;
      done_next    = 1'b0;
      error_next   = error_reg;
      rd_addr      = '0;
      case (state_reg)
         IDLE: begin
            if (I_start && !I_abort) begin
               if (I_len == '0 || I_len > MAX_LEN) begin
                  error_next = 1'b1;
                  done_next  = 1'b1;
               end else begin
                  len_next    = I_len;
                  crc_en_next = I_crc_enable;
                  error_next  = 1'b0;
                  quiet_next  = 1'b0;
                  state_next  = WAIT_BUS;
               end
            end
         end
         WAIT_BUS: begin
            if (I_abort) begin
               opmode_next = 2'b01;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else if (fe_rxactive) begin
               quiet_next = 1'b0;
            end else if (quiet_reg) begin
               opmode_next = 2'b00;
               turn_next   = '0;
               state_next  = PRE;
            end else begin
               quiet_next = 1'b1;
            end
         end
         PRE: begin
            if (I_abort) begin
               opmode_next = 2'b01;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else if (turn_done) begin
               txvalid_next = 1'b1;
               idx_next     = '0;
               to_next      = '0;
               crc_next     = 16'hFFFF;
               state_next   = TX;
            end else begin
               turn_next = turn_reg + TC_W'(1);
            end
         end
         TX: begin
            rd_addr = consume ? W'(idx_reg + (W+2)'(1)) : W'(idx_reg);
            if (I_abort) begin
               txvalid_next = 1'b0;
               turn_next    = '0;
               state_next   = POST;
            end else if (consume) begin
               to_next = '0;
               if (idx_reg != '0 && idx_reg < len_ext)
                  crc_next = crc16_byte(crc_reg, tx_byte);
               if (is_last) begin
                  txvalid_next = 1'b0;
                  turn_next    = '0;
                  state_next   = POST;
               end else begin
                  idx_next = idx_reg + (W+2)'(1);
               end
            end else if (to_reg == TO_W'(pTXREADY_TIMEOUT - 1)) begin
               error_next   = 1'b1;
               txvalid_next = 1'b0;
               turn_next    = '0;
               state_next   = POST;
            end else begin
               to_next = to_reg + TO_W'(1);
            end
         end
         POST: begin
            if (turn_done) begin
               opmode_next = 2'b01;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else begin
               turn_next = turn_reg + TC_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign O_fe_data    = txvalid_reg ? tx_byte : 8'h00;
   assign O_fe_txvalid = txvalid_reg;
   assign O_opmode     = opmode_reg;
   assign O_busy       = (state_reg != IDLE);
   assign O_done       = done_reg;
   assign O_error      = error_reg;

endmodule
